// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg: shared types and constants for the pattern scan sequencer
package pattern_scan_ctrl_pkg;
    typedef enum logic [2:0] {POS_0, POS_1, POS_2, POS_3, POS_4, POS_5, POS_6, POS_7} BitPosition_mne;
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SCAN_X, SCAN_IN, DONE} ScanState_e;
    localparam int SCAN_IN_LEN = 5;
    localparam int SCAN_X_LEN = 3;
    localparam int SCAN_X_FIRST_POS = 2;
endpackage

// File: rtl/patr.sv
// Patr: combinational 4-bit pattern checker; position p tests bits [p+2:p-1] of PatrSrcA
module Patr
    import pattern_scan_ctrl_pkg::*;
(
    input  logic [7:0]     PatrSrcA,
    input  logic [7:0]     PatrSrcB,
    input  BitPosition_mne PatternPosition,
    output logic           PatrOut
);
    logic [3:0] window;
    always_comb begin
        window = 4'(PatrSrcA >> (PatternPosition - 3'd1));
        PatrOut = PatternPosition != POS_0 && {4'b0, window} == PatrSrcB;
    end
endmodule

// File: rtl/pattern_scan_ctrl_sat_counter.sv
// sat_counter: synchronous-clear up counter that holds at all-ones
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);
    always_ff @(posedge CLK or negedge ResetN)
        if (!ResetN)
            value <= '0;
        else
            value <= clear ? '0 : (inc && value != '1) ? value + 1'b1 : value;
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: steps Patr over each byte and each byte boundary of a message,
// counting pattern occurrences and bytes containing at least one in-byte hit.
module pattern_scan_ctrl
    import pattern_scan_ctrl_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int HIT_W = 6
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [3:0]       Pattern,
    input  logic             ByteValid,
    input  logic [7:0]       ByteData,
    input  logic             LastByte,
    output logic             ByteReady,
    output logic [7:0]       PatrSrcA,
    output logic [7:0]       PatrSrcB,
    output BitPosition_mne   PatternPosition,
    input  logic             PatrOut,
    output logic [CNT_W-1:0] TotalCnt,
    output logic [HIT_W-1:0] ByteHitCnt,
    output logic             Busy,
    output logic             Done
);
    ScanState_e state, nextState;
    logic [7:0] cur;
    logic [3:0] prevHi, pat;
    logic [2:0] step;
    logic last, first, hitFlag;
    logic startAcc, scanning, xEnd, inEnd;

    always_ff @(posedge CLK or negedge ResetN)
        if (!ResetN)
            state <= IDLE;
        else
            state <= nextState;

    always_comb begin
        nextState = state;
        startAcc = Start && (state == IDLE || state == DONE);
        scanning = state == SCAN_X || state == SCAN_IN;
        xEnd = state == SCAN_X && step == 3'(SCAN_X_LEN - 1);
        inEnd = state == SCAN_IN && step == 3'(SCAN_IN_LEN - 1);
        ByteReady = state == WAIT_BYTE;
        Busy = state == WAIT_BYTE || scanning;
        Done = state == DONE;
        PatrSrcB = {4'b0, pat};
        PatrSrcA = state == SCAN_X ? {cur[3:0], prevHi} : state == SCAN_IN ? cur : 8'd0;
        PatternPosition = state == SCAN_X  ? BitPosition_mne'(3'(SCAN_X_FIRST_POS) + step) :
                          state == SCAN_IN ? BitPosition_mne'(3'd1 + step) : POS_1;
        case (state)
            IDLE, DONE: nextState = Start ? WAIT_BYTE : state;
            WAIT_BYTE:  nextState = !ByteValid ? WAIT_BYTE : first ? SCAN_IN : SCAN_X;
            SCAN_X:     nextState = xEnd ? SCAN_IN : SCAN_X;
            SCAN_IN:    nextState = !inEnd ? SCAN_IN : last ? DONE : WAIT_BYTE;
            default:    nextState = IDLE;
        endcase
    end

    // step restarts at 0 on entry to each scan phase
    always_ff @(posedge CLK or negedge ResetN)
        if (!ResetN) begin
            cur <= '0;
            prevHi <= '0;
            pat <= '0;
            step <= '0;
            last <= 1'b0;
            first <= 1'b1;
            hitFlag <= 1'b0;
        end else begin
            step <= (!scanning || xEnd || inEnd) ? 3'd0 : step + 3'd1;
            hitFlag <= inEnd ? 1'b0 : state == SCAN_IN ? hitFlag | PatrOut : hitFlag;
            if (startAcc) begin
                pat <= Pattern;
                first <= 1'b1;
            end
            if (ByteReady && ByteValid) begin
                cur <= ByteData;
                last <= LastByte;
            end
            if (inEnd) begin
                prevHi <= cur[7:4];
                first <= 1'b0;
            end
        end

    sat_counter #(.WIDTH(CNT_W)) totalCtr (
        .CLK(CLK), .ResetN(ResetN), .clear(startAcc), .inc(scanning && PatrOut), .value(TotalCnt)
    );

    sat_counter #(.WIDTH(HIT_W)) hitCtr (
        .CLK(CLK), .ResetN(ResetN), .clear(startAcc), .inc(inEnd && (hitFlag || PatrOut)), .value(ByteHitCnt)
    );
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed scenarios for pattern_scan_ctrl with Patr attached;
// a second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_pattern_scan_ctrl;
    import pattern_scan_ctrl_pkg::*;

    logic CLK, ResetN, Start, ByteValid, LastByte;
    logic [3:0] Pattern;
    logic [7:0] ByteData;
    logic ByteReady, Busy, Done, PatrOut;
    logic [7:0] PatrSrcA, PatrSrcB;
    BitPosition_mne PatternPosition;
    logic [7:0] TotalCnt;
    logic [5:0] ByteHitCnt;
    logic sByteReady, sBusy, sDone, sPatrOut;
    logic [7:0] sPatrSrcA, sPatrSrcB;
    BitPosition_mne sPatternPosition;
    logic [1:0] sTotalCnt;
    logic [5:0] sByteHitCnt;
    int checks = 0;
    int errors = 0;

    pattern_scan_ctrl dut (
        .CLK(CLK), .ResetN(ResetN), .Start(Start), .Pattern(Pattern), .ByteValid(ByteValid),
        .ByteData(ByteData), .LastByte(LastByte), .ByteReady(ByteReady), .PatrSrcA(PatrSrcA),
        .PatrSrcB(PatrSrcB), .PatternPosition(PatternPosition), .PatrOut(PatrOut),
        .TotalCnt(TotalCnt), .ByteHitCnt(ByteHitCnt), .Busy(Busy), .Done(Done)
    );
    Patr patr (.PatrSrcA(PatrSrcA), .PatrSrcB(PatrSrcB), .PatternPosition(PatternPosition), .PatrOut(PatrOut));

    pattern_scan_ctrl #(.CNT_W(2)) dutSat (
        .CLK(CLK), .ResetN(ResetN), .Start(Start), .Pattern(Pattern), .ByteValid(ByteValid),
        .ByteData(ByteData), .LastByte(LastByte), .ByteReady(sByteReady), .PatrSrcA(sPatrSrcA),
        .PatrSrcB(sPatrSrcB), .PatternPosition(sPatternPosition), .PatrOut(sPatrOut),
        .TotalCnt(sTotalCnt), .ByteHitCnt(sByteHitCnt), .Busy(sBusy), .Done(sDone)
    );
    Patr patrSat (.PatrSrcA(sPatrSrcA), .PatrSrcB(sPatrSrcB), .PatternPosition(sPatternPosition), .PatrOut(sPatrOut));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic startScan(input logic [3:0] p);
        Pattern = p;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic l);
        int n = 0;
        ByteValid = 1'b1;
        ByteData = d;
        LastByte = l;
        while (!ByteReady && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (ByteReady !== 1'b1) begin
            errors++;
            $display("FAIL handshake byte %h: ByteReady=%b required 1", d, ByteReady);
        end
        @(posedge CLK);
        #1;
        ByteValid = 1'b0;
        LastByte = 1'b0;
    endtask

    task automatic countEdges(input bit forDone, output int n);
        n = 0;
        while (!(forDone ? Done : ByteReady) && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        ResetN = 1'b0;
        Start = 1'b0;
        Pattern = 4'd0;
        ByteValid = 1'b0;
        ByteData = 8'd0;
        LastByte = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({ByteReady, Busy, Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: ready/busy/done=%b required 000", {ByteReady, Busy, Done});
        end
        checks++;
        if (TotalCnt !== 8'd0 || ByteHitCnt !== 6'd0 || sTotalCnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_counts: total=%0d hits=%0d satTotal=%0d required 0", TotalCnt, ByteHitCnt, sTotalCnt);
        end
        checks++;
        if (PatrSrcA !== 8'd0 || PatrSrcB !== 8'd0 || PatternPosition !== POS_1) begin
            errors++;
            $display("FAIL reset_patr: srcA=%h srcB=%h pos=%0d required 00 00 1", PatrSrcA, PatrSrcB, PatternPosition);
        end
        ResetN = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single_byte;
        int n;
        startScan(4'b1010);
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0 || PatrSrcB !== 8'h0A) begin
            errors++;
            $display("FAIL single_start: busy=%b done=%b srcB=%h required 1 0 0a", Busy, Done, PatrSrcB);
        end
        sendByte(8'h0A, 1'b1);
        countEdges(1'b1, n);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL single_latency: %0d edges after handshake, required 5", n);
        end
        checks++;
        if (TotalCnt !== 8'd1 || ByteHitCnt !== 6'd1) begin
            errors++;
            $display("FAIL single_counts: total=%0d hits=%0d required 1 1", TotalCnt, ByteHitCnt);
        end
        checks++;
        if (Busy !== 1'b0 || ByteReady !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b ready=%b required 0 0", Busy, ByteReady);
        end
    endtask

    task automatic test_boundary_aa;
        int n;
        startScan(4'b1010);
        checks++;
        if (TotalCnt !== 8'd0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: total=%0d done=%b required 0 0", TotalCnt, Done);
        end
        sendByte(8'hAA, 1'b0);
        countEdges(1'b0, n);
        checks++;
        if (n !== 5 || TotalCnt !== 8'd3 || ByteHitCnt !== 6'd1) begin
            errors++;
            $display("FAIL aa_first: edges=%0d total=%0d hits=%0d required 5 3 1", n, TotalCnt, ByteHitCnt);
        end
        sendByte(8'hAA, 1'b1);
        countEdges(1'b1, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL aa_latency: %0d edges after handshake, required 8", n);
        end
        checks++;
        if (TotalCnt !== 8'd7 || ByteHitCnt !== 6'd2) begin
            errors++;
            $display("FAIL aa_counts: total=%0d hits=%0d required 7 2", TotalCnt, ByteHitCnt);
        end
    endtask

    task automatic test_boundary_only;
        int n;
        startScan(4'b1010);
        sendByte(8'h80, 1'b0);
        countEdges(1'b0, n);
        sendByte(8'h02, 1'b1);
        countEdges(1'b1, n);
        checks++;
        if (TotalCnt !== 8'd1 || ByteHitCnt !== 6'd0 || Done !== 1'b1) begin
            errors++;
            $display("FAIL boundary_only: total=%0d hits=%0d done=%b required 1 0 1", TotalCnt, ByteHitCnt, Done);
        end
    endtask

    task automatic test_stall;
        int n;
        int bad = 0;
        startScan(4'b1010);
        sendByte(8'hAA, 1'b0);
        countEdges(1'b0, n);
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (ByteReady !== 1'b1 || Busy !== 1'b1 || TotalCnt !== 8'd3) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: %0d stalled cycles lost ready/busy/count, required 0", bad);
        end
        sendByte(8'hAA, 1'b1);
        countEdges(1'b1, n);
        checks++;
        if (n !== 8 || TotalCnt !== 8'd7 || ByteHitCnt !== 6'd2) begin
            errors++;
            $display("FAIL stall_counts: edges=%0d total=%0d hits=%0d required 8 7 2", n, TotalCnt, ByteHitCnt);
        end
    endtask

    task automatic test_async_reset;
        int n;
        startScan(4'b1010);
        sendByte(8'hAA, 1'b0);
        countEdges(1'b0, n);
        sendByte(8'hAA, 1'b0);
        repeat (4) @(posedge CLK);
        #2;
        checks++;
        if (PatternPosition !== POS_2 || PatrSrcA !== 8'hAA) begin
            errors++;
            $display("FAIL mid_scan_in: pos=%0d srcA=%h required 2 aa", PatternPosition, PatrSrcA);
        end
        ResetN = 1'b0;
        #1;
        checks++;
        if ({ByteReady, Busy, Done} !== 3'b000 || TotalCnt !== 8'd0 || ByteHitCnt !== 6'd0 || PatrSrcA !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: flags=%b total=%0d hits=%0d srcA=%h required 000 0 0 00",
                     {ByteReady, Busy, Done}, TotalCnt, ByteHitCnt, PatrSrcA);
        end
        @(posedge CLK);
        #1;
        ResetN = 1'b1;
        @(posedge CLK);
        #1;
        startScan(4'b1010);
        sendByte(8'h0A, 1'b1);
        countEdges(1'b1, n);
        checks++;
        if (n !== 5 || TotalCnt !== 8'd1 || ByteHitCnt !== 6'd1) begin
            errors++;
            $display("FAIL post_reset: edges=%0d total=%0d hits=%0d required 5 1 1", n, TotalCnt, ByteHitCnt);
        end
    endtask

    task automatic test_saturation;
        int n;
        startScan(4'b1010);
        sendByte(8'hAA, 1'b0);
        countEdges(1'b0, n);
        sendByte(8'hAA, 1'b1);
        @(posedge CLK);
        #1;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        countEdges(1'b1, n);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL start_ignored_latency: %0d edges, required 6", n);
        end
        checks++;
        if (sTotalCnt !== 2'd3 || sByteHitCnt !== 6'd2 || sDone !== 1'b1) begin
            errors++;
            $display("FAIL sat_counts: total=%0d hits=%0d done=%b required 3 2 1", sTotalCnt, sByteHitCnt, sDone);
        end
        checks++;
        if (TotalCnt !== 8'd7) begin
            errors++;
            $display("FAIL wide_counts: total=%0d required 7", TotalCnt);
        end
        startScan(4'b1010);
        checks++;
        if (sTotalCnt !== 2'd0 || sByteHitCnt !== 6'd0 || sDone !== 1'b0 || sBusy !== 1'b1) begin
            errors++;
            $display("FAIL sat_clear: total=%0d hits=%0d done=%b busy=%b required 0 0 0 1",
                     sTotalCnt, sByteHitCnt, sDone, sBusy);
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_boundary_aa;
        test_boundary_only;
        test_stall;
        test_async_reset;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
